bids22_round_sequencer: RTL and testbench
=========================================

# bids22_round_sequencer

Control-side sequencer that drives the `bids22` auction unit's configuration port (`C_op`, `C_data`, `C_start`) through one complete auction round. On a `go` pulse it:

- snapshots a configuration set;
- issues the load, mask, timer and charge operations while the unit is unlocked;
- locks the unit and holds `C_start` for a programmed number of cycles;
- waits for `roundOver`, then unlocks the unit with the same key.

It sits between the system host/testbench and `bids22`, so software never sequences raw opcodes.

## Interface
- `ROUND_W`, 16, width of `round_len` and the round cycle counter
- `DRAIN_TIMEOUT`, 8, maximum cycles to wait for `roundOver` after `C_start` drops
- `clk` in 1: single clock, all logic on rising edge
- `reset_n` in 1: asynchronous, active-low reset
- `go` in 1: start request; sampled only in IDLE, ignored while `busy`=1
- `abort` in 1: terminate the sequence early; sampled in every non-IDLE state
- `cfg_xval`, `cfg_yval`, `cfg_zval` in 32 each: starting balances for X, Y and Z
- `cfg_mask` in 3: bidder enable mask, bit0 = X
- `cfg_timer` in 32: lockout timer value
- `cfg_cost` in 32: per-bid charge
- `cfg_key` in 32: lock/unlock key
- `round_len` in ROUND_W: number of cycles `C_start` is held high (0 is treated as 1)
- `ready` in 1: from the auction unit
- `roundOver` in 1: from the auction unit
- `err` in 2: from the auction unit
- `C_op` out 4: opcode to the auction unit
- `C_data` out 32: data to the auction unit
- `C_start` out 1: round start to the auction unit
- `busy` out 1: 1 in any state other than IDLE
- `done` out 1: one-cycle pulse when a sequence ends
- `fail` out 1: valid with `done`
- `last_err` out 2: unit `err` captured on failure; held until the next accepted `go`
- `phase` out 3: current state encoding

## Operation
- Opcodes: NoOp=0, Unlock=1, Lock=2, LoadX=3, LoadY=4, LoadZ=5, SetXYZmask=6, SetTimer=7, BidCharge=8.
- All outputs are registered.
- On `go` in IDLE, all `cfg_*` inputs and `round_len` are snapshotted. Later changes to them have no effect until the next sequence.
- States, with `phase` encoding:
  - IDLE (0): `C_op`=NoOp, `C_start`=0.
  - CONFIG (1): issues LoadX, LoadY, LoadZ, SetXYZmask (`C_data`={29'b0,mask}), SetTimer, BidCharge.
    - One op per cycle, and only while `ready`=1.
    - When `ready`=0 the block drives `C_op`=NoOp and the step index holds.
  - LOCK (2): issues Lock with `C_data`=key for one cycle (also gated by `ready`).
  - ROUND (3): `C_start`=1, `C_op`=NoOp.
    - The down-counter loads `max(round_len,1)` and decrements each cycle.
    - The state exits when the counter reaches 1.
  - DRAIN (4): `C_start`=0, `C_op`=NoOp.
    - Exits to UNLOCK when `roundOver`=1 is sampled.
    - After DRAIN_TIMEOUT cycles without `roundOver`, sets the fail flag and still proceeds to UNLOCK.
  - UNLOCK (5): issues Unlock with `C_data`=key for one cycle.
  - DONE (6): `done`=1 for one cycle, then IDLE.
- Error check: `err`≠0 sampled in CONFIG or LOCK captures `last_err`, sets fail, and goes directly to DONE. No Lock is issued in that case.
- `abort` sets the sticky fail flag and acts by state:
  - in CONFIG or LOCK: go to DONE next cycle;
  - in ROUND: `C_start` drops next cycle and the state moves to DRAIN;
  - in DRAIN or UNLOCK: the sequence continues normally.
- `abort` and `go` together in IDLE: `go` is accepted; `abort` is ignored that cycle.
- The round counter is exactly ROUND_W bits with no wrap: it never decrements below 1.
- The DRAIN timeout counter is $clog2(DRAIN_TIMEOUT+1) bits.

## Timing
- Reset values: `C_op`=0, `C_data`=0, `C_start`=0, `busy`=0, `done`=0, `fail`=0, `last_err`=0, `phase`=0. The fail flag and all counters are cleared.
- Reset asserted mid-sequence returns the block to IDLE immediately and the outputs go to their reset values. The auction unit is not unlocked by this block.
- Clean sequence with `ready`=1 throughout, `go` sampled at edge 0, `roundOver` high in the first DRAIN cycle:
  - cycles 1–6: CONFIG ops;
  - cycle 7: Lock;
  - cycles 8..7+N: `C_start`=1;
  - cycle 8+N: DRAIN;
  - cycle 9+N: Unlock;
  - cycle 10+N: `done`.
- Each `ready`=0 cycle in CONFIG/LOCK adds one cycle of latency.
- `done` and `fail` are asserted in the same cycle.
- `busy` falls in the cycle after `done`.
- A new `go` is accepted in the first IDLE cycle.

## Test plan
- Basic round: xval=100, yval=200, zval=300, mask=3'b111, timer=15, cost=1, key=32'h0F0F0F0F, round_len=4, `ready`=1, `roundOver` on the first DRAIN cycle.
  - Op sequence must be 3,4,5,6,7,8,2, then `C_start` high exactly 4 cycles, then Unlock(32'h0F0F0F0F).
  - `done` at cycle 14, `fail`=0.
- `ready` low for cycles 2–3 during CONFIG: NoOp is driven during the stall, no op is skipped or duplicated, and `done` arrives 2 cycles later than the basic round.
- `err`=2'b11 raised while LoadY is issued: no Lock is issued, `done`=1 with `fail`=1, and `last_err`=2'b11 is held until the next `go`.
- round_len=0: `C_start` is high exactly 1 cycle. round_len=16'hFFFF: `C_start` is high exactly 65535 cycles.
- `roundOver` never asserted: DRAIN lasts 8 cycles, Unlock is still issued, and `done`+`fail` are raised.
- `abort` on the second ROUND cycle with round_len=10: `C_start` is high only 2 cycles, DRAIN and Unlock still occur, and `fail`=1. A separate check asserts `reset_n` low mid-CONFIG: outputs go to reset values asynchronously.

Source files
------------

// File: rtl/bids22_round_sequencer.sv
// bids22_round_sequencer
//   Drives the bids22 configuration port through one auction round:
//   config loads -> Lock -> C_start for round_len cycles -> wait roundOver
//   -> Unlock -> done pulse.
// Ports:
//   clk, reset_n              clock, async active-low reset
//   go, abort                 sequence start / early termination
//   cfg_*, round_len          configuration, snapshotted on accepted go
//   ready, roundOver, err     status from the auction unit
//   C_op, C_data, C_start     configuration port to the auction unit
//   busy, done, fail,         sequence status
//   last_err, phase
module bids22_round_sequencer #(
   parameter int ROUND_W       = 16,
   parameter int DRAIN_TIMEOUT = 8
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               go,
   input  logic               abort,
   input  logic [31:0]        cfg_xval,
   input  logic [31:0]        cfg_yval,
   input  logic [31:0]        cfg_zval,
   input  logic [2:0]         cfg_mask,
   input  logic [31:0]        cfg_timer,
   input  logic [31:0]        cfg_cost,
   input  logic [31:0]        cfg_key,
   input  logic [ROUND_W-1:0] round_len,
   input  logic               ready,
   input  logic               roundOver,
   input  logic [1:0]         err,
   output logic [3:0]         C_op,
   output logic [31:0]        C_data,
   output logic               C_start,
   output logic               busy,
   output logic               done,
   output logic               fail,
   output logic [1:0]         last_err,
   output logic [2:0]         phase
);

   localparam int TW = $clog2(DRAIN_TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_CONFIG = 3'd1,
      S_LOCK   = 3'd2,
      S_ROUND  = 3'd3,
      S_DRAIN  = 3'd4,
      S_UNLOCK = 3'd5,
      S_DONE   = 3'd6
   } state_t;

   typedef enum logic [3:0] {
      OP_NOOP   = 4'd0,
      OP_UNLOCK = 4'd1,
      OP_LOCK   = 4'd2,
      OP_LOADX  = 4'd3,
      OP_LOADY  = 4'd4,
      OP_LOADZ  = 4'd5,
      OP_MASK   = 4'd6,
      OP_TIMER  = 4'd7,
      OP_CHARGE = 4'd8
   } op_t;

   state_t             r_state;
   logic [2:0]         r_step;   // number of CONFIG/LOCK ops already issued
   logic [ROUND_W-1:0] r_cnt;
   logic [TW-1:0]      r_tmo;
   logic               r_fail;
   logic [31:0]        r_x, r_y, r_z, r_timer, r_cost, r_key;
   logic [2:0]         r_mask;
   logic [ROUND_W-1:0] r_len;

   logic [31:0]        w_x, w_y, w_z, w_timer, w_cost, w_key;
   logic [2:0]         w_mask;
   op_t                w_op;
   logic [31:0]        w_data;

   assign phase = r_state;

   // The first op goes out on the same edge that accepts go, so in IDLE
   // the op data comes straight from the cfg inputs instead of the snapshot.
   always_comb begin
      w_x     = r_x;
      w_y     = r_y;
      w_z     = r_z;
      w_mask  = r_mask;
      w_timer = r_timer;
      w_cost  = r_cost;
      w_key   = r_key;
      if (r_state == S_IDLE) begin
         w_x     = cfg_xval;
         w_y     = cfg_yval;
         w_z     = cfg_zval;
         w_mask  = cfg_mask;
         w_timer = cfg_timer;
         w_cost  = cfg_cost;
         w_key   = cfg_key;
      end
      w_op   = OP_NOOP;
      w_data = '0;
      case (r_step)
         3'd0: begin w_op = OP_LOADX;  w_data = w_x;             end
         3'd1: begin w_op = OP_LOADY;  w_data = w_y;             end
         3'd2: begin w_op = OP_LOADZ;  w_data = w_z;             end
         3'd3: begin w_op = OP_MASK;   w_data = {29'b0, w_mask}; end
         3'd4: begin w_op = OP_TIMER;  w_data = w_timer;         end
         3'd5: begin w_op = OP_CHARGE; w_data = w_cost;          end
         3'd6: begin w_op = OP_LOCK;   w_data = w_key;           end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= S_IDLE;
         r_step   <= '0;
         r_cnt    <= '0;
         r_tmo    <= '0;
         r_fail   <= 1'b0;
         r_x      <= '0;
         r_y      <= '0;
         r_z      <= '0;
         r_mask   <= '0;
         r_timer  <= '0;
         r_cost   <= '0;
         r_key    <= '0;
         r_len    <= '0;
         C_op     <= '0;
         C_data   <= '0;
         C_start  <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         fail     <= 1'b0;
         last_err <= '0;
      end else begin
         C_op   <= OP_NOOP;
         C_data <= '0;
         done   <= 1'b0;
         if (r_state != S_IDLE && abort) r_fail <= 1'b1;
         case (r_state)
            S_IDLE: begin
               C_start <= 1'b0;
               if (go) begin
                  r_x      <= cfg_xval;
                  r_y      <= cfg_yval;
                  r_z      <= cfg_zval;
                  r_mask   <= cfg_mask;
                  r_timer  <= cfg_timer;
                  r_cost   <= cfg_cost;
                  r_key    <= cfg_key;
                  r_len    <= round_len;
                  r_fail   <= 1'b0;
                  last_err <= '0;
                  busy     <= 1'b1;
                  r_state  <= S_CONFIG;
                  if (ready) begin
                     C_op   <= w_op;
                     C_data <= w_data;
                     r_step <= 3'd1;
                  end
               end
            end
            S_CONFIG, S_LOCK: begin
               if (err != 2'b00) begin
                  last_err <= err;
                  r_fail   <= 1'b1;
                  fail     <= 1'b1;
                  done     <= 1'b1;
                  r_state  <= S_DONE;
               end else if (abort) begin
                  fail    <= 1'b1;
                  done    <= 1'b1;
                  r_state <= S_DONE;
               end else if (r_step == 3'd7) begin
                  // Lock was presented during this cycle
                  C_start <= 1'b1;
                  r_cnt   <= (r_len == '0) ? ROUND_W'(1) : r_len;
                  r_state <= S_ROUND;
               end else begin
                  r_state <= (r_step == 3'd6) ? S_LOCK : S_CONFIG;
                  if (ready) begin
                     C_op   <= w_op;
                     C_data <= w_data;
                     r_step <= r_step + 3'd1;
                  end
               end
            end
            S_ROUND: begin
               if (abort || r_cnt == ROUND_W'(1)) begin
                  C_start <= 1'b0;
                  r_tmo   <= '0;
                  r_state <= S_DRAIN;
               end else begin
                  r_cnt <= r_cnt - ROUND_W'(1);
               end
            end
            S_DRAIN: begin
               if (roundOver || r_tmo == TW'(DRAIN_TIMEOUT - 1)) begin
                  if (!roundOver) r_fail <= 1'b1;
                  C_op    <= OP_UNLOCK;
                  C_data  <= r_key;
                  r_state <= S_UNLOCK;
               end else begin
                  r_tmo <= r_tmo + TW'(1);
               end
            end
            S_UNLOCK: begin
               done    <= 1'b1;
               fail    <= r_fail | abort;
               r_state <= S_DONE;
            end
            S_DONE: begin
               busy    <= 1'b0;
               fail    <= 1'b0;
               r_step  <= '0;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bids22_round_sequencer.sv
// Scoreboard bench for bids22_round_sequencer: each sequence pushes its
// expected op / C_start-run / done events; a negedge monitor pops and
// compares whenever the DUT presents one.
module tb_bids22_round_sequencer;

   localparam int ROUND_W = 16;
   localparam int DTO     = 8;

   localparam int K_OP    = 0;
   localparam int K_START = 1;
   localparam int K_DONE  = 2;

   logic               clk = 1'b0;
   logic               reset_n;
   logic               go, abort, ready, roundOver;
   logic [31:0]        cfg_xval, cfg_yval, cfg_zval, cfg_timer, cfg_cost, cfg_key;
   logic [2:0]         cfg_mask;
   logic [ROUND_W-1:0] round_len;
   logic [1:0]         err;
   logic [3:0]         C_op;
   logic [31:0]        C_data;
   logic               C_start, busy, done, fail;
   logic [1:0]         last_err;
   logic [2:0]         phase;

   bids22_round_sequencer #(.ROUND_W(ROUND_W), .DRAIN_TIMEOUT(DTO)) dut (
      .clk(clk), .reset_n(reset_n), .go(go), .abort(abort),
      .cfg_xval(cfg_xval), .cfg_yval(cfg_yval), .cfg_zval(cfg_zval),
      .cfg_mask(cfg_mask), .cfg_timer(cfg_timer), .cfg_cost(cfg_cost),
      .cfg_key(cfg_key), .round_len(round_len), .ready(ready),
      .roundOver(roundOver), .err(err), .C_op(C_op), .C_data(C_data),
      .C_start(C_start), .busy(busy), .done(done), .fail(fail),
      .last_err(last_err), .phase(phase)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          kind;
      logic [3:0]  op;
      logic [31:0] data;
      int          len;
      logic        fl;
      logic [1:0]  le;
      int          cyc;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   edge_n   = 0;
   int   g_edge   = 0;
   int   run_len  = 0;
   int   rel;
   bit   mon_en   = 1'b0;
   bit   done_seen;

   // configuration of the next sequence
   logic [31:0] tx, ty, tz, tt, tc, tk;
   logic [2:0]  tm;

   always @(posedge clk) edge_n <= edge_n + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
      end
   endtask

   task automatic pop_exp(input string what, output exp_t e, output bit ok);
      ok = 1'b0;
      if (q.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL unexpected %s: got an output, expected none (t=%0t)", what, $time);
      end else begin
         e  = q.pop_front();
         ok = 1'b1;
      end
   endtask

   task automatic push(input int kind, input logic [3:0] op, input logic [31:0] d,
                       input int len, input logic fl, input logic [1:0] le, input int cyc);
      exp_t e;
      e.kind = kind; e.op = op; e.data = d; e.len = len;
      e.fl = fl; e.le = le; e.cyc = cyc;
      q.push_back(e);
   endtask

   // monitor
   always @(negedge clk) begin
      exp_t e;
      bit   ok;
      if (mon_en) begin
         rel = edge_n - g_edge + 1;
         if (C_op !== 4'd0) begin
            pop_exp("op", e, ok);
            if (ok) begin
               chk("op kind", 64'(K_OP), 64'(e.kind));
               chk("C_op", 64'(C_op), 64'(e.op));
               chk("C_data", 64'(C_data), 64'(e.data));
            end
         end
         if (C_start === 1'b1) begin
            run_len++;
         end else if (run_len > 0) begin
            pop_exp("C_start run", e, ok);
            if (ok) begin
               chk("start kind", 64'(K_START), 64'(e.kind));
               chk("C_start length", 64'(run_len), 64'(e.len));
            end
            run_len = 0;
         end
         if (done === 1'b1) begin
            pop_exp("done", e, ok);
            if (ok) begin
               chk("done kind", 64'(K_DONE), 64'(e.kind));
               chk("fail", 64'(fail), 64'(e.fl));
               chk("last_err", 64'(last_err), 64'(e.le));
               chk("done cycle", 64'(rel), 64'(e.cyc));
            end
            done_seen = 1'b1;
         end
      end
   end

   function automatic logic [31:0] rnd32();
      return $urandom;
   endfunction

   task automatic clear_inputs();
      go = 1'b0; abort = 1'b0; ready = 1'b1; roundOver = 1'b0; err = 2'b00;
   endtask

   // n: round_len; s/sl: ready-low window start/length (cycles after go);
   // et/ev: err value raised on cycle et (0 = none); a: abort on ROUND
   // cycle a (0 = none); d: roundOver on DRAIN cycle d (0 = never).
   task automatic run_seq(input int n, input int s, input int sl, input int et,
                          input logic [1:0] ev, input int a, input int d);
      logic [3:0]  ops[7];
      logic [31:0] dat[7];
      int neff, l, dl, sdone, limit;
      logic [1:0] exp_le;
      ops = '{4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd2};
      dat = '{tx, ty, tz, {29'b0, tm}, tt, tc, tk};
      l = 0;
      if (et > 0) begin
         for (int i = 0; i < et; i++) push(K_OP, ops[i], dat[i], 0, 0, 0, 0);
         sdone  = et + 1;
         exp_le = ev;
         push(K_DONE, 0, 0, 0, 1'b1, ev, sdone);
      end else begin
         for (int i = 0; i < 7; i++) push(K_OP, ops[i], dat[i], 0, 0, 0, 0);
         neff   = (n == 0) ? 1 : n;
         l      = (a > 0 && a < neff) ? a : neff;
         dl     = (d > 0) ? d : DTO;
         sdone  = 7 + sl + l + dl + 2;
         exp_le = 2'b00;
         push(K_START, 0, 0, l, 0, 0, 0);
         push(K_OP, 4'd1, tk, 0, 0, 0, 0);
         push(K_DONE, 0, 0, 0, (a > 0) || (d == 0), 2'b00, sdone);
      end

      @(posedge clk); #1;
      clear_inputs();
      go = 1'b1;
      cfg_xval = tx; cfg_yval = ty; cfg_zval = tz; cfg_mask = tm;
      cfg_timer = tt; cfg_cost = tc; cfg_key = tk;
      round_len = n[ROUND_W-1:0];
      done_seen = 1'b0;
      @(posedge clk); #1;
      g_edge = edge_n;
      go = 1'b0;
      // snapshot must make these irrelevant
      cfg_xval = rnd32(); cfg_yval = rnd32(); cfg_zval = rnd32();
      cfg_timer = rnd32(); cfg_cost = rnd32(); cfg_key = rnd32();
      cfg_mask = 3'($urandom_range(0, 7));
      round_len = ROUND_W'($urandom_range(0, 40));
      limit = sdone + 10;
      for (int k = 1; k <= limit && !done_seen; k++) begin
         ready     = !(sl > 0 && k >= s && k < s + sl);
         err       = (k == et) ? ev : 2'b00;
         abort     = (a > 0 && k == 7 + sl + a);
         roundOver = (d > 0 && et == 0 && k == 7 + sl + l + d);
         @(posedge clk); #1;
      end
      clear_inputs();
      if (!done_seen) begin
         n_checks++;
         n_fail++;
         $display("FAIL done timeout: got no done within %0d cycles, expected done at cycle %0d", limit, sdone);
         q.delete();
         run_len = 0;
      end
      repeat (3) @(posedge clk);
      #1;
      chk("busy after done", 64'(busy), 64'(0));
      chk("last_err held", 64'(last_err), 64'(exp_le));
      chk("scoreboard drained", 64'(q.size()), 64'(0));
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, " C_op"},     64'(C_op),     64'(0));
      chk({tag, " C_data"},   64'(C_data),   64'(0));
      chk({tag, " C_start"},  64'(C_start),  64'(0));
      chk({tag, " busy"},     64'(busy),     64'(0));
      chk({tag, " done"},     64'(done),     64'(0));
      chk({tag, " fail"},     64'(fail),     64'(0));
      chk({tag, " last_err"}, 64'(last_err), 64'(0));
      chk({tag, " phase"},    64'(phase),    64'(0));
   endtask

   task automatic basic_cfg();
      tx = 32'd100; ty = 32'd200; tz = 32'd300; tm = 3'b111;
      tt = 32'd15; tc = 32'd1; tk = 32'h0F0F0F0F;
   endtask

   initial begin
      int n, neff, a;
      reset_n = 1'b0;
      clear_inputs();
      cfg_xval = '0; cfg_yval = '0; cfg_zval = '0; cfg_mask = '0;
      cfg_timer = '0; cfg_cost = '0; cfg_key = '0; round_len = '0;
      #12;
      check_reset_outputs("reset");
      @(negedge clk);
      reset_n = 1'b1;
      mon_en  = 1'b1;

      basic_cfg();
      run_seq(4, 0, 0, 0, 2'b00, 0, 1);        // basic round, done at 14
      run_seq(4, 2, 2, 0, 2'b00, 0, 1);        // ready low cycles 2-3
      run_seq(4, 0, 0, 2, 2'b11, 0, 1);        // err during LoadY
      run_seq(0, 0, 0, 0, 2'b00, 0, 1);        // round_len 0
      run_seq(4, 0, 0, 0, 2'b00, 0, 0);        // roundOver never comes
      run_seq(10, 0, 0, 0, 2'b00, 2, 1);       // abort on 2nd ROUND cycle
      run_seq(65535, 0, 0, 0, 2'b00, 0, 1);    // longest round

      for (int i = 0; i < 8; i++) begin
         tx = rnd32(); ty = rnd32(); tz = rnd32(); tt = rnd32();
         tc = rnd32(); tk = rnd32(); tm = 3'($urandom_range(0, 7));
         if (i % 4 == 3) begin
            run_seq(5, 0, 0, $urandom_range(1, 7), 2'($urandom_range(1, 3)), 0, 0);
         end else begin
            n    = $urandom_range(0, 20);
            neff = (n == 0) ? 1 : n;
            a    = ($urandom_range(0, 2) == 0) ? $urandom_range(1, neff) : 0;
            run_seq(n, $urandom_range(1, 4), $urandom_range(0, 2), 0, 2'b00,
                    a, $urandom_range(0, DTO));
         end
      end

      // asynchronous reset in the middle of CONFIG
      mon_en = 1'b0;
      basic_cfg();
      @(posedge clk); #1;
      go = 1'b1;
      cfg_xval = tx; cfg_yval = ty; cfg_zval = tz; cfg_mask = tm;
      cfg_timer = tt; cfg_cost = tc; cfg_key = tk; round_len = 16'd4;
      @(posedge clk); #1;
      go = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #3;
      chk("busy before reset", 64'(busy), 64'(1));
      reset_n = 1'b0;
      #1;
      check_reset_outputs("mid-config reset");
      @(negedge clk);
      reset_n = 1'b1;
      q.delete();
      run_len = 0;
      mon_en  = 1'b1;
      run_seq(4, 0, 0, 0, 2'b00, 0, 1);        // recovery after reset

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
